// File: rtl/pitch_pkg.sv
// Shared defaults for the pitch-detection FFT back end (mag-squared stage and peak search).
package pitch_pkg;
  localparam int unsigned DATA_WIDTH_DEF = 48;
  localparam int unsigned MAG_WIDTH_DEF  = 96;
  localparam int unsigned K_WIDTH_DEF    = 12;
  localparam int unsigned FFT_LEN_DEF    = 4096;
  // Clocks from input accept to data_valid; used to align the peak-search frame reset.
  localparam int unsigned MAG_LATENCY    = 3;
  // Flags carried beside the bin index in the sideband bus (frame_first, frame_last).
  localparam int unsigned SB_FLAG_BITS   = 2;
endpackage

// File: rtl/mag_sq_pipe.sv
// Three-stage signed square-and-add datapath with a pass-through sideband bus.
module mag_sq_pipe #(
  parameter int unsigned DATA_WIDTH = 48,
  parameter int unsigned MAG_WIDTH  = 96,
  parameter int unsigned SB_WIDTH   = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_re,
  input  logic [DATA_WIDTH-1:0] i_im,
  input  logic [SB_WIDTH-1:0]   i_sb,
  output logic                  o_valid,
  output logic [MAG_WIDTH-1:0]  o_mag,
  output logic [SB_WIDTH-1:0]   o_sb
);
  localparam int unsigned SQ_WIDTH = 2 * DATA_WIDTH;

  logic                         r_v1, r_v2;
  logic signed [DATA_WIDTH-1:0] r_re1, r_im1;
  logic [SB_WIDTH-1:0]          r_sb1, r_sb2;
  logic signed [SQ_WIDTH-1:0]   r_re_sq, r_im_sq;
  logic signed [SQ_WIDTH-1:0]   w_re_ext, w_im_ext;
  logic [SQ_WIDTH-1:0]          w_sum;

  assign w_re_ext = SQ_WIDTH'(r_re1);
  assign w_im_ext = SQ_WIDTH'(r_im1);
  // Both squares are non-negative and each is at most 2**(SQ_WIDTH-2), so the sum cannot carry out.
  assign w_sum    = $unsigned(r_re_sq) + $unsigned(r_im_sq);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      o_valid <= 1'b0;
      r_re1   <= '0;
      r_im1   <= '0;
      r_sb1   <= '0;
      r_re_sq <= '0;
      r_im_sq <= '0;
      r_sb2   <= '0;
      o_mag   <= '0;
      o_sb    <= '0;
    end else begin
      r_v1    <= i_valid;
      r_v2    <= r_v1;
      o_valid <= r_v2;
      // Data registers load only behind a valid so outputs hold across bubbles.
      if (i_valid) begin
        r_re1 <= $signed(i_re);
        r_im1 <= $signed(i_im);
        r_sb1 <= i_sb;
      end
      if (r_v1) begin
        r_re_sq <= w_re_ext * w_re_ext;
        r_im_sq <= w_im_ext * w_im_ext;
        r_sb2   <= r_sb1;
      end
      if (r_v2) begin
        o_mag <= MAG_WIDTH'(w_sum);
        o_sb  <= r_sb2;
      end
    end
  end
endmodule

// File: rtl/fft_mag_sq_stream.sv
// Streaming |X|^2 stage: bin index counter, framing checks and the mag-squared pipeline.
module fft_mag_sq_stream
  import pitch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned MAG_WIDTH  = MAG_WIDTH_DEF,
  parameter int unsigned K_WIDTH    = K_WIDTH_DEF,
  parameter int unsigned FFT_LEN    = FFT_LEN_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_tdata_re,
  input  logic [DATA_WIDTH-1:0] s_tdata_im,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  output logic                  s_tready,
  output logic                  data_valid,
  output logic [MAG_WIDTH-1:0]  data_out,
  output logic [K_WIDTH-1:0]    k_out,
  output logic                  frame_first,
  output logic                  frame_last,
  output logic                  frame_err
);
  localparam int unsigned        SB_WIDTH = K_WIDTH + SB_FLAG_BITS;
  localparam logic [K_WIDTH-1:0] K_LAST   = K_WIDTH'(FFT_LEN - 1);

  logic                r_tready;
  logic [K_WIDTH-1:0]  r_k;
  logic                r_err;
  logic                w_accept;
  logic                w_k_max;
  logic                w_last;
  logic [SB_WIDTH-1:0] w_sb_in;
  logic [SB_WIDTH-1:0] w_sb_out;

  assign w_accept = s_tvalid & r_tready;
  assign w_k_max  = (r_k == K_LAST);
  assign w_last   = s_tlast | w_k_max;
  assign w_sb_in  = {r_k, (r_k == '0), w_last};

  // Bin counter and sticky framing error; a mismatch between tlast and the final index is an error.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tready <= 1'b0;
      r_k      <= '0;
      r_err    <= 1'b0;
    end else begin
      r_tready <= 1'b1;
      if (w_accept) begin
        r_k <= w_last ? '0 : r_k + K_WIDTH'(1);
        if (s_tlast != w_k_max) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  mag_sq_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAG_WIDTH  (MAG_WIDTH),
    .SB_WIDTH   (SB_WIDTH)
  ) u_pipe (
    .clock   (clock),
    .reset   (reset),
    .i_valid (w_accept),
    .i_re    (s_tdata_re),
    .i_im    (s_tdata_im),
    .i_sb    (w_sb_in),
    .o_valid (data_valid),
    .o_mag   (data_out),
    .o_sb    (w_sb_out)
  );

  assign s_tready    = r_tready;
  assign k_out       = w_sb_out[SB_WIDTH-1:SB_FLAG_BITS];
  assign frame_first = w_sb_out[1];
  assign frame_last  = w_sb_out[0];
  assign frame_err   = r_err;
endmodule

// File: tb/tb_fft_mag_sq_stream.sv
// Self-checking bench for fft_mag_sq_stream: queue-based output model plus hand-computed checks.
module tb_fft_mag_sq_stream;
  localparam int DW = 48;
  localparam int MW = 96;
  localparam int KW = 12;
  localparam int N  = 4096;
  localparam int INF = 32'h7fff_ffff;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] s_tdata_re = '0;
  logic [DW-1:0] s_tdata_im = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic          data_valid;
  logic [MW-1:0] data_out;
  logic [KW-1:0] k_out;
  logic          frame_first;
  logic          frame_last;
  logic          frame_err;

  fft_mag_sq_stream #(.DATA_WIDTH(DW), .MAG_WIDTH(MW), .K_WIDTH(KW), .FFT_LEN(N)) dut (
    .clock(clock), .reset(reset), .s_tdata_re(s_tdata_re), .s_tdata_im(s_tdata_im),
    .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready), .data_valid(data_valid),
    .data_out(data_out), .k_out(k_out), .frame_first(frame_first), .frame_last(frame_last),
    .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int            cyc;
    logic [MW-1:0] mag;
    logic [KW-1:0] k;
    logic          first;
    logic          last;
  } exp_t;

  exp_t          q[$];
  int            cyc = 0;
  int            n_tests = 0;
  int            n_fail = 0;
  int            k_model = 0;
  int            err_cyc = INF;
  int            rdy_cyc = INF;
  bit            chk_en = 1'b0;
  logic [MW-1:0] last_mag = '0;
  logic [KW-1:0] last_k = '0;
  logic          last_first = 1'b0;
  logic          last_last = 1'b0;
  logic [MW-1:0] pk_max = '0;
  logic [KW-1:0] pk_k = '0;
  logic [KW-1:0] frame_peak_k = '0;
  int            n_last_seen = 0;

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Every-cycle compare of all outputs against the model queue.
  initial forever begin
    @(negedge clock);
    if (chk_en) begin
      if (reset) begin
        check("rst_valid", 96'(data_valid), '0);
        check("rst_data", data_out, '0);
        check("rst_k", 96'(k_out), '0);
        check("rst_flags", 96'({frame_first, frame_last, frame_err}), '0);
        check("rst_tready", 96'(s_tready), '0);
      end else begin
        check("tready", 96'(s_tready), 96'(cyc >= rdy_cyc));
        check("frame_err", 96'(frame_err), 96'(cyc >= err_cyc));
        if (q.size() > 0 && q[0].cyc == cyc) begin
          exp_t e;
          e = q.pop_front();
          check("valid", 96'(data_valid), 96'(1));
          last_mag = e.mag; last_k = e.k; last_first = e.first; last_last = e.last;
          if (frame_first || data_out > pk_max) begin
            pk_max = data_out;
            pk_k = k_out;
          end
          if (frame_last) begin
            frame_peak_k = pk_k;
            n_last_seen++;
          end
        end else begin
          check("idle_valid", 96'(data_valid), '0);
        end
        check("data_out", data_out, last_mag);
        check("k_out", 96'(k_out), 96'(last_k));
        check("frame_first", 96'(frame_first), 96'(last_first));
        check("frame_last", 96'(frame_last), 96'(last_last));
      end
    end
  end

  task automatic send(input logic signed [DW-1:0] re, input logic signed [DW-1:0] im, input logic last);
    exp_t e;
    logic signed [MW-1:0] r, i;
    logic kmax;
    s_tdata_re = re; s_tdata_im = im; s_tvalid = 1'b1; s_tlast = last;
    r = 96'(re); i = 96'(im);
    kmax = (k_model == N - 1);
    e.cyc = cyc + 3;
    e.mag = r * r + i * i;
    e.k = 12'(k_model);
    e.first = (k_model == 0);
    e.last = last || kmax;
    if (last != kmax && err_cyc == INF) err_cyc = cyc + 1;
    k_model = e.last ? 0 : k_model + 1;
    q.push_back(e);
    @(posedge clock); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    q.delete();
    last_mag = '0; last_k = '0; last_first = 1'b0; last_last = 1'b0;
    err_cyc = INF; rdy_cyc = INF; k_model = 0;
    #1;
    chk_en = 1'b1;
    check("async_valid", 96'(data_valid), '0);
    check("async_data", data_out, '0);
    check("async_tready", 96'(s_tready), '0);
    check("async_err", 96'(frame_err), '0);
    @(posedge clock); @(posedge clock);
    #2 reset = 1'b0;
    rdy_cyc = cyc + 1;
    @(posedge clock); #1;
  endtask

  initial begin
    logic signed [DW-1:0] neg_max, pos_max;
    neg_max = {1'b1, {(DW-1){1'b0}}};
    pos_max = {1'b0, {(DW-1){1'b1}}};

    // First bin after reset
    do_reset();
    send(48'sd3, -48'sd4, 1'b0);
    idle(2);
    check("t1_valid", 96'(data_valid), 96'(1));
    check("t1_mag", data_out, 96'd25);
    check("t1_k", 96'(k_out), '0);
    check("t1_first", 96'(frame_first), 96'(1));

    // Valid toggling 1,0,0,1,1 then extreme operands
    do_reset();
    send(48'sd1, 48'sd1, 1'b0);
    idle(2);
    send(48'sd2, 48'sd2, 1'b0);
    send(-48'sd5, 48'sd12, 1'b0);
    idle(2);
    check("t5_k", 96'(k_out), 96'd2);
    check("t5_mag", data_out, 96'd169);
    send(neg_max, neg_max, 1'b0);
    idle(2);
    check("t3_negmax", data_out, 96'h800000000000000000000000);
    send(pos_max, 48'sd0, 1'b0);
    idle(2);
    check("t3_posmax", data_out, 96'h3FFFFFFFFFFF000000000001);
    idle(2);

    // Full well-formed frame with peak at bin 1000
    do_reset();
    n_last_seen = 0;
    for (int k = 0; k < N; k++)
      send((k == 1000) ? 48'sd100000 : 48'(k % 97), -48'(k % 13), k == N - 1);
    idle(4);
    check("t2_peak_k", 96'(frame_peak_k), 96'd1000);
    check("t2_last_cnt", 96'(n_last_seen), 96'd1);
    check("t2_err", 96'(frame_err), '0);

    // Early tlast at k=9
    for (int k = 0; k < 9; k++) send(48'(k), 48'sd0, 1'b0);
    check("t4_err_pre", 96'(frame_err), '0);
    send(48'sd9, 48'sd0, 1'b1);
    check("t4_err_set", 96'(frame_err), 96'(1));
    send(48'sd20, 48'sd0, 1'b0);
    idle(2);
    check("t4_k_resync", 96'(k_out), '0);
    check("t4_err_hold", 96'(frame_err), 96'(1));

    // Missing tlast at k=N-1
    do_reset();
    for (int k = 0; k < N; k++) send(48'(k % 31), 48'sd1, 1'b0);
    check("t4b_err_set", 96'(frame_err), 96'(1));
    send(48'sd6, 48'sd8, 1'b0);
    idle(2);
    check("t4b_k_wrap", 96'(k_out), '0);
    check("t4b_mag", data_out, 96'd100);

    // Reset with bins in flight
    do_reset();
    send(48'sd7, 48'sd7, 1'b0);
    send(48'sd8, 48'sd8, 1'b0);
    idle(1);
    check("t6_live_valid", 96'(data_valid), 96'(1));
    do_reset();
    idle(5);
    send(48'sd1, -48'sd2, 1'b0);
    idle(2);
    check("t6_k0", 96'(k_out), '0);
    check("t6_mag", data_out, 96'd5);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
